// File: rtl/lrf_aer_pkg.sv
// Shared types and constants for the AER rate encoder and its handshake master.
package lrf_aer_pkg;

    localparam logic [1:0] AER_TYPE_SPK   = 2'b00;
    localparam logic [1:0] AER_TYPE_TSTEP = 2'b01;

    typedef enum logic [2:0] {
        ENC_IDLE,
        ENC_SCAN,
        ENC_SPK_WAIT,
        ENC_MSETUP,
        ENC_MRK_WAIT,
        ENC_DONE
    } enc_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_REQ,
        TX_RELEASE
    } tx_state_t;

    function automatic int aer_width(input int c, input int h, input int w);
        return 2 + $clog2(c) + $clog2(h) + $clog2(w);
    endfunction

endpackage

// File: rtl/aer_tx_handshake.sv
// Four-phase AER master: latches one address on send, runs SETUP/REQ/RELEASE,
// and pulses sent once ACK has returned low.
module aer_tx_handshake
    import lrf_aer_pkg::*;
#(
    parameter int AER_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [AER_WIDTH-1:0] addr_in,
    output logic                 sent,
    output logic                 req,
    output logic [AER_WIDTH-1:0] addr,
    input  logic                 ack
);

    tx_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_nxt;
    end

    // Address is only reloaded from idle, so it stays put until ACK has dropped.
    always_ff @(posedge clk) begin
        if (rst)                          addr <= '0;
        else if (state == TX_IDLE && send) addr <= addr_in;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:    if (send) state_nxt = TX_SETUP;
            TX_SETUP:   if (!ack) state_nxt = TX_REQ;
            TX_REQ:     if (ack)  state_nxt = TX_RELEASE;
            TX_RELEASE: if (!ack) state_nxt = TX_IDLE;
            default:    state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        req  = (state == TX_REQ);
        sent = (state == TX_RELEASE) && !ack;
    end

endmodule

// File: rtl/aer_rate_encoder.sv
// Rate-coded AER encoder: accumulates pixel intensities per time step and emits
// a spike event on each accumulator carry, plus a marker after every step.
module aer_rate_encoder
    import lrf_aer_pkg::*;
#(
    parameter int FM_W      = 16,
    parameter int FM_H      = 16,
    parameter int FM_C      = 3,
    parameter int TIME_STEP = 8,
    parameter int PIX_WIDTH = 8,
    parameter int AER_WIDTH = aer_width(FM_C, FM_H, FM_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    input  logic                 PIX_WE,
    input  logic [AER_WIDTH-3:0] PIX_WADDR,
    input  logic [PIX_WIDTH-1:0] PIX_WDATA,
    output logic                 AER_REQ,
    output logic [AER_WIDTH-1:0] AER_ADDR,
    input  logic                 AER_ACK
);

    localparam int IDX_W = AER_WIDTH - 2;
    localparam int NPIX  = FM_C * FM_H * FM_W;
    localparam int T_W   = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;

    logic [PIX_WIDTH-1:0] pix [NPIX];
    logic [PIX_WIDTH-1:0] acc [NPIX];

    enc_state_t           state, state_nxt;
    logic [IDX_W-1:0]     p;
    logic [T_W-1:0]       t;
    logic [PIX_WIDTH:0]   sum;
    logic                 spike, last_pix, last_step, start_ok;
    logic                 tx_send, tx_sent;
    logic [AER_WIDTH-1:0] tx_addr;

    assign start_ok  = (state == ENC_IDLE) && START;
    assign sum       = {1'b0, acc[p]} + {1'b0, pix[p]};
    assign spike     = sum[PIX_WIDTH];
    assign last_pix  = (p == IDX_W'(NPIX - 1));
    assign last_step = (t == T_W'(TIME_STEP - 1));

    // Pixel memory survives reset; writes are only taken while idle.
    always_ff @(posedge clk) begin
        if (PIX_WE && state == ENC_IDLE && {1'b0, PIX_WADDR} < (IDX_W+1)'(NPIX))
            pix[PIX_WADDR] <= PIX_WDATA;
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            for (int i = 0; i < NPIX; i++) acc[i] <= '0;
        end else if (state == ENC_SCAN) begin
            acc[p] <= sum[PIX_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
            t <= '0;
        end else begin
            case (state)
                ENC_IDLE: if (START) begin
                    p <= '0;
                    t <= '0;
                end
                ENC_SCAN:     if (!spike && !last_pix) p <= p + 1'b1;
                ENC_SPK_WAIT: if (tx_sent && !last_pix) p <= p + 1'b1;
                ENC_MRK_WAIT: if (tx_sent && !last_step) begin
                    t <= t + 1'b1;
                    p <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ENC_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENC_IDLE:     if (START) state_nxt = ENC_SCAN;
            ENC_SCAN:     if (spike) state_nxt = ENC_SPK_WAIT;
                          else if (last_pix) state_nxt = ENC_MSETUP;
            ENC_SPK_WAIT: if (tx_sent) state_nxt = last_pix ? ENC_MSETUP : ENC_SCAN;
            ENC_MSETUP:   state_nxt = ENC_MRK_WAIT;
            ENC_MRK_WAIT: if (tx_sent) state_nxt = last_step ? ENC_DONE : ENC_SCAN;
            ENC_DONE:     state_nxt = ENC_IDLE;
            default:      state_nxt = ENC_IDLE;
        endcase
    end

    always_comb begin
        tx_send = (state == ENC_SCAN && spike) || (state == ENC_MSETUP);
        tx_addr = (state == ENC_MSETUP) ? {AER_TYPE_TSTEP, IDX_W'(0)} : {AER_TYPE_SPK, p};
        BUSY    = (state != ENC_IDLE);
        DONE    = (state == ENC_DONE);
    end

    aer_tx_handshake #(
        .AER_WIDTH (AER_WIDTH)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .send    (tx_send),
        .addr_in (tx_addr),
        .sent    (tx_sent),
        .req     (AER_REQ),
        .addr    (AER_ADDR),
        .ack     (AER_ACK)
    );

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Randomized bench for aer_rate_encoder with a spike-count reference model and
// a configurable-latency AER responder.
module tb_aer_rate_encoder;

    localparam int NPIX = 3 * 16 * 16;
    localparam int TS   = 8;
    localparam int THR  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        START = 1'b0;
    logic        BUSY, DONE;
    logic        PIX_WE = 1'b0;
    logic [9:0]  PIX_WADDR = '0;
    logic [7:0]  PIX_WDATA = '0;
    logic        AER_REQ;
    logic [11:0] AER_ADDR;
    logic        AER_ACK = 1'b0;

    aer_rate_encoder dut (
        .clk(clk), .rst(rst), .START(START), .BUSY(BUSY), .DONE(DONE),
        .PIX_WE(PIX_WE), .PIX_WADDR(PIX_WADDR), .PIX_WDATA(PIX_WDATA),
        .AER_REQ(AER_REQ), .AER_ADDR(AER_ADDR), .AER_ACK(AER_ACK)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int mpix [NPIX];
    logic [11:0] exp_q [$];
    logic [11:0] ev_q  [$];
    int done_cnt, viol, addr_viol;
    int ack_dly = 0, hold_cnt = 0, dly = 0;
    logic req_q = 1'b0, in_hs = 1'b0;
    logic [11:0] hs_addr = '0, addr_prev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // Monitor and responder share one negedge process so their ordering is fixed.
    initial forever begin
        @(negedge clk);
        if (rst) in_hs = 1'b0;
        if (AER_REQ && !req_q) begin
            ev_q.push_back(AER_ADDR);
            if (AER_ACK) viol++;
            if (AER_ADDR !== addr_prev) addr_viol++;
            hs_addr = AER_ADDR;
            in_hs   = 1'b1;
        end
        if (in_hs && AER_ADDR !== hs_addr) addr_viol++;
        if (in_hs && !AER_REQ && !AER_ACK) in_hs = 1'b0;
        if (DONE) done_cnt++;
        req_q     = AER_REQ;
        addr_prev = AER_ADDR;
        if (hold_cnt > 0) begin
            hold_cnt--;
            AER_ACK = 1'b1;
            dly = 0;
        end else if (AER_REQ != AER_ACK) begin
            if (dly >= ack_dly) begin
                AER_ACK = AER_REQ;
                dly = 0;
            end else dly++;
        end else dly = 0;
    end

    // Spike on step k (1-based) whenever floor(k*v/THR) advances.
    function automatic void build_exp();
        exp_q.delete();
        for (int s = 0; s < TS; s++) begin
            for (int i = 0; i < NPIX; i++)
                if (((s + 1) * mpix[i]) / THR > (s * mpix[i]) / THR)
                    exp_q.push_back({2'b00, 10'(i)});
            exp_q.push_back(12'h400);
        end
    endfunction

    task automatic wr(input int idx, input int val);
        @(negedge clk);
        PIX_WE = 1'b1; PIX_WADDR = 10'(idx); PIX_WDATA = 8'(val);
        mpix[idx] = val;
        @(negedge clk);
        PIX_WE = 1'b0;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NPIX; i++) if (mpix[i] != 0) wr(i, 0);
    endtask

    task automatic run(input string tag, input int d, input int hold,
                       input int sw_idx, input int sw_val, input bit poke);
        int fails0, cyc;
        ack_dly = d;
        if (sw_idx >= 0) mpix[sw_idx] = sw_val;
        build_exp();
        ev_q.delete(); done_cnt = 0; viol = 0; addr_viol = 0;
        fails0 = n_chk - n_pass;
        hold_cnt = hold;
        @(negedge clk);
        START = 1'b1;
        if (sw_idx >= 0) begin
            PIX_WE = 1'b1; PIX_WADDR = 10'(sw_idx); PIX_WDATA = 8'(sw_val);
        end
        @(negedge clk);
        START = 1'b0; PIX_WE = 1'b0;
        chk({tag, ".busy_rise"}, BUSY, 1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 100) begin
                START = 1'b1; PIX_WE = 1'b1; PIX_WADDR = 10'd5; PIX_WDATA = 8'hff;
            end else begin
                START = 1'b0; PIX_WE = 1'b0;
            end
        end
        START = 1'b0; PIX_WE = 1'b0;
        chk({tag, ".timeout"}, (done_cnt == 0), 0);
        repeat (3) @(negedge clk);
        chk({tag, ".busy_low"}, BUSY, 0);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".req_while_ack"}, viol, 0);
        chk({tag, ".addr_stable"}, addr_viol, 0);
        chk({tag, ".ev_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            chk({tag, $sformatf(".ev%0d", i)}, ev_q[i], exp_q[i]);
            if (n_chk - n_pass != fails0) break;
        end
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NPIX; i++) mpix[i] = -1;

        repeat (3) @(negedge clk);
        chk("rst.req", AER_REQ, 0);
        chk("rst.addr", AER_ADDR, 0);
        chk("rst.busy", BUSY, 0);
        chk("rst.done", DONE, 0);
        rst = 1'b0;

        for (int i = 0; i < NPIX; i++) wr(i, 0);
        run("zero", 0, 0, -1, 0, 1'b0);

        wr(1 * 256 + 2 * 16 + 3, 128);
        run("px128", 0, 0, -1, 0, 1'b0);
        chk("px128.spikes", exp_q.size() - TS, 4);
        clear_frame();

        wr(10, 255);
        wr(300, 32);
        run("extreme", 0, 0, 700, 1, 1'b0);
        chk("extreme.spikes", exp_q.size() - TS, 8);
        clear_frame();

        for (int k = 0; k < 16; k++) wr($urandom_range(0, NPIX - 1), $urandom_range(0, 255));
        run("rand_a", 0, 0, -1, 0, 1'b1);
        run("slow", 5, 20, -1, 0, 1'b0);
        clear_frame();

        for (int k = 0; k < 12; k++) wr($urandom_range(0, NPIX - 1), $urandom_range(0, 255));
        wr(0, 200);
        build_exp();
        ack_dly = 0;
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        cyc = 0;
        while (!AER_REQ && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid.req_seen", AER_REQ, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.req_fall", AER_REQ, 0);
        chk("rstmid.busy", BUSY, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run("rerun", 0, 0, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
